mp_add_sequencer: RTL and testbench

Multi-precision add/subtract controller that time-shares one N_WIDTH-bit ripple_adder across a W = N_WIDTH*N_CHUNKS-bit operand pair. Operands arrive and results leave over valid/ready handshakes. An FSM feeds one chunk per cycle, LSB chunk first, with the inter-chunk carry held in a register. The block sits between wide-datapath producers and consumers where a full-width combinational adder is too large or too slow.

---
 rtl/mp_add_pkg.sv | 15 +
 rtl/full_adder.sv | 13 +
 rtl/ripple_adder.sv | 28 ++
 rtl/mp_add_sequencer.sv | 112 +++++++++++
 tb/tb_mp_add_sequencer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mp_add_pkg.sv
// Shared types and helpers for the multi-precision add/subtract sequencer.
package mp_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Chunk index width; a single-chunk sequencer still needs one bit.
  function automatic int idx_width(input int n_chunks);
    return (n_chunks > 1) ? $clog2(n_chunks) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder, the cell of the shared ripple adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/ripple_adder.sv
// N_WIDTH-bit combinational ripple-carry adder built from full_adder cells.
module ripple_adder #(
  parameter int N_WIDTH = 4
) (
  input  logic [N_WIDTH-1:0] a,
  input  logic [N_WIDTH-1:0] b,
  input  logic               c_in,
  output logic [N_WIDTH-1:0] sum,
  output logic               c_out
);

  logic [N_WIDTH:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < N_WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .c_in (carry[i]),
      .sum  (sum[i]),
      .c_out(carry[i+1])
    );
  end

  assign c_out = carry[N_WIDTH];

endmodule

// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract: one N_WIDTH-bit ripple adder reused over
// N_CHUNKS cycles, LSB chunk first, with the inter-chunk carry in a register.
module mp_add_sequencer
  import mp_add_pkg::*;
#(
  parameter  int N_WIDTH  = 4,
  parameter  int N_CHUNKS = 4,
  localparam int W        = N_WIDTH * N_CHUNKS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         busy
);

  localparam int IW = idx_width(N_CHUNKS);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE (and never during reset); out_valid is high
  // only in DONE, so accept and release can never share an edge.
  state_t state, next_state;

  logic [N_CHUNKS-1:0][N_WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic [IW-1:0]      idx;
  logic               carry;
  logic               last;
  logic [N_WIDTH-1:0] a_chunk, b_chunk, add_sum;
  logic               add_co;

  assign last      = (idx == IW'(N_CHUNKS - 1));
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_reg;

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < N_CHUNKS; i++) begin
      if (idx == IW'(i)) begin
        a_chunk = a_reg[i];
        b_chunk = b_reg[i];
      end
    end
  end

  ripple_adder #(.N_WIDTH(N_WIDTH)) u_adder (
    .a    (a_chunk),
    .b    (b_chunk),
    .c_in (carry),
    .sum  (add_sum),
    .c_out(add_co)
  );

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (in_valid) next_state = RUN;
      RUN:     if (last) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      c_out   <= 1'b0;
    end else begin
      state <= next_state;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1: invert B once here, seed carry with 1.
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub ? 1'b1 : c_in;
            idx   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < N_CHUNKS; i++) begin
            if (idx == IW'(i)) sum_reg[i] <= add_sum;
          end
          carry <= add_co;
          if (last) begin
            c_out <= add_co;
            idx   <= '0;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Self-checking bench for mp_add_sequencer (4x4-bit and 1x4-bit instances).
module tb_mp_add_sequencer;

  localparam int NW = 4;
  localparam int NC = 4;
  localparam int W  = NW * NC;
  localparam int W1 = NW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, c_in, sub, out_valid, out_ready, c_out, busy;
  logic [W-1:0] a, b, sum;

  logic          s_in_valid, s_in_ready, s_c_in, s_sub, s_out_valid, s_out_ready, s_c_out, s_busy;
  logic [W1-1:0] s_a, s_b, s_sum;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  mp_add_sequencer #(.N_WIDTH(NW), .N_CHUNKS(NC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .c_in(c_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .busy(busy)
  );

  mp_add_sequencer #(.N_WIDTH(NW), .N_CHUNKS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .a(s_a), .b(s_b),
    .c_in(s_c_in), .sub(s_sub), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .sum(s_sum), .c_out(s_c_out), .busy(s_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Plain unsigned arithmetic: {carry/no-borrow, w-bit result}.
  function automatic logic [31:0] ref_model(input longint unsigned x, input longint unsigned y,
                                            input bit ci, input bit s, input int w);
    longint unsigned mask, r;
    mask = (64'd1 << w) - 1;
    if (s) begin
      r = (x - y) & mask;
      return 32'(((x >= y) ? (64'd1 << w) : 64'd0) | r);
    end
    r = x + y + ci;
    return 32'(r & ((mask << 1) | 64'd1));
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic tc,
                        input logic ts, input int hold, input string tag);
    logic [31:0] e;
    int lat;
    e = ref_model(ta, tb_b, tc, ts, W);
    @(negedge clk);
    wait_ready();
    a = ta; b = tb_b; c_in = tc; sub = ts;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(NC));
    check({tag, "_result"}, 32'({c_out, sum}), e);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    if (hold > 0) begin
      in_valid = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_hold_result"}, 32'({c_out, sum}), e);
        check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
    end
    check({tag, "_released"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] e;
    int sent, got, cyc;
    bit acc_pending, saw_valid;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_c_in = 1'b0; s_sub = 1'b0; s_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_result", 32'({c_out, sum}), 32'd0);
    rst = 1'b0;
    #1;
    check("reset_release_in_ready", 32'(in_ready), 32'd1);

    run_op(16'h1234, 16'h0FCC, 1'b0, 1'b0, 0, "add_basic");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, "add_wrap");
    run_op(16'h00FF, 16'h0000, 1'b1, 1'b0, 0, "add_cin");
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 0, "sub_pos");
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, "sub_neg");

    run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 6, "backpressure");
    run_op(16'hABCD, 16'h1234, 1'b0, 1'b1, 0, "bp_second");

    // Abort an addition after two chunks have been processed.
    @(negedge clk);
    wait_ready();
    a = 16'hFFFF; b = 16'h0001; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_result", 32'({c_out, sum}), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    saw_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("abort_no_output", 32'(saw_valid), 32'd0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, "after_abort");

    // Random traffic with random gaps on both sides.
    sent = 0; got = 0; cyc = 0; acc_pending = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    while (got < 200 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (acc_pending) in_valid = 1'b0;
      if (!in_valid) begin
        a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
        if (sent < 200 && $urandom_range(0, 3) != 0) in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_result", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("rand_result", 32'({c_out, sum}), e);
        end
        got++;
      end
      acc_pending = in_valid && in_ready;
      if (acc_pending) begin
        exp_q.push_back(ref_model(a, b, c_in, sub, W));
        sent++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("rand_results_seen", 32'(got), 32'd200);
    check("rand_sent", 32'(sent), 32'd200);
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    // Single-chunk instance: RUN lasts exactly one cycle.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("c1_in_ready", 32'(s_in_ready), 32'd1);
      s_a = 4'($urandom); s_b = 4'($urandom); s_c_in = 1'($urandom); s_sub = 1'($urandom);
      s_in_valid = 1'b1;
      s_out_ready = 1'b1;
      e = ref_model(s_a, s_b, s_c_in, s_sub, W1);
      @(posedge clk);
      #1;
      s_in_valid = 1'b0;
      s_a = 4'($urandom); s_b = 4'($urandom);
      @(negedge clk);
      check("c1_run_no_valid", 32'(s_out_valid), 32'd0);
      @(negedge clk);
      check("c1_valid", 32'(s_out_valid), 32'd1);
      check("c1_result", 32'({s_c_out, s_sum}), e);
      @(negedge clk);
      check("c1_released", 32'(s_out_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
